fp_mul_exp_pack: RTL and testbench
==================================

Name: fp_mul_exp_pack

Overview:
- Back-end stage of the approximate floating-point multiplier. Sits directly downstream of the approximate mantissa multiplier, which supplies a pre-normalised mantissa and a 2-bit normalisation shift code.
- Computes the sign and the biased exponent, applies the shift adjustment, and handles zero/inf/NaN and overflow/underflow.
- Packs the result word behind a 2-stage valid/ready pipeline.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- MANTISSA_WIDTH, 15, stored fraction width; equals the mantissa unit's MANTISSA_WIDTH.
- BIAS, 2**(EXP_WIDTH-1)-1, exponent bias.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/mantissa bundle valid.
- in_ready  out  1  stage can accept the bundle this cycle.
- sign_x, sign_y  in  1 each  operand signs.
- exp_x, exp_y  in  EXP_WIDTH each  biased operand exponents.
- frac_x_nz, frac_y_nz  in  1 each  operand fraction is non-zero (used for NaN detection).
- mant_in  in  MANTISSA_WIDTH  normalised product fraction from the mantissa unit.
- shift_in  in  2  normalisation code from the mantissa unit: bit1 = product in [2,4), bit0 = product in [1,2).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  1+EXP_WIDTH+MANTISSA_WIDTH  packed result: {sign, exp, frac}.
- flags  out  4  {invalid, overflow, underflow, inexact_special}; valid with out_valid.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. On rst, s1_valid, s2_valid, out_valid, result and flags all go to 0. in_ready is 0 during the rst cycle and 1 in the first cycle after.
- Transfer: occurs when valid && ready on a given side. in_ready = !s1_valid || adv1. adv1 = !s2_valid || out_ready. Pipeline bubbles collapse. There is no combinational path from in_valid to out_valid.
- Latency: 2 cycles from input transfer to out_valid when out_ready is held high. Throughput: 1 result per cycle.
- Stall: when out_valid && !out_ready, result and flags hold stable and stage 1 holds. in_ready falls only when both stages are full.
- Stage 1, registered on input transfer:
  - sgn = sign_x ^ sign_y.
  - Each operand is classified as ZERO (exp==0; denormals flush to zero), INF (exp all-ones, !frac_nz), NAN (exp all-ones, frac_nz), or NORM.
  - e1 = exp_x + exp_y - BIAS, computed in signed EXP_WIDTH+2 bits.
  - mant_in and shift_in are captured unchanged.
- Stage 2, registered on adv1:
  - adj = +1 if shift[1]; 0 if shift==2'b01; -1 if shift==2'b00. Code 2'b11 is treated as +1, since bit1 dominates.
  - e2 = e1 + adj.
- Priority at stage 2:
  1. Any NAN operand, or INF*ZERO → canonical NaN {0, all-ones, 1 followed by zeros}. invalid=1 only for INF*ZERO.
  2. Any INF → {sgn, all-ones, 0}.
  3. Any ZERO → {sgn, 0, 0}.
  4. e2 >= 2**EXP_WIDTH-1 → {sgn, all-ones, 0}, overflow=1.
  5. e2 <= 0 → {sgn, 0, 0}, underflow=1 (flush to zero).
  6. Otherwise → {sgn, e2[EXP_WIDTH-1:0], mant}.
- inexact_special is set for cases 4 and 5 only.
- Arithmetic: no wrap-around is allowed. The intermediate width of EXP_WIDTH+2 covers the range -BIAS-1 .. 2*(2**EXP_WIDTH-1)-BIAS+1.
- Reset mid-operation: all in-flight entries are discarded. No output appears until a new input is accepted.
- Simultaneous input transfer and output transfer with both stages full: both complete in the same cycle and occupancy stays at 2.

Decomposition:
- Package fp_mul_pkg holds:
  - EXP_WIDTH, MANTISSA_WIDTH, BIAS;
  - typedef fp_class_t {ZERO, NORM, INF, NAN};
  - the canonical-NaN and infinity exponent constants;
  - flag bit indices.
- Sub-module fp_operand_classify: combinational {exp, frac_nz} → fp_class_t, instantiated once per operand.
- Everything else is inline: the pipeline regs, the handshake, and the stage-2 priority mux.

Test Plan (defaults E=8, M=15, BIAS=127):
- 1.0×1.0: exp 127/127, mant 0, shift 01, out_ready=1 → result 0x3F8000 two cycles later, flags 0.
- shift 10, mant 0x2000, exp 127/127, signs 1/0 → result 0xC02000. Then shift 00, same exps → exp 126, result 0xBF2000 (sign 1).
- Overflow/underflow: exp 200/200 → 0x7F8000 with overflow=1. exp 10/10 → 0x000000 with underflow=1. exp 127/1, shift 00 → e2=0 → zero with underflow=1.
- Specials: exp 255 frac_nz=1 × any → 0x7FC000. INF × ZERO (exp 255/0, frac_nz 0/0) → 0x7FC000 with invalid=1. INF × 1.0, sign_x=1 → 0xFF8000.
- Back-pressure: stream 4 bundles with out_ready low for cycles 2-5 → in_ready drops after 2 accepts, results hold stable, all 4 emerge in order with no loss or duplication. Then assert rst while full → out_valid=0 next cycle and no stale result afterward.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared constants and types for the approximate FP multiplier back end.
package fp_mul_pkg;

    localparam int EXP_WIDTH      = 8;
    localparam int MANTISSA_WIDTH = 15;
    localparam int BIAS           = 2**(EXP_WIDTH-1) - 1;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    // Infinity and NaN share the all-ones exponent; canonical NaN has only the fraction MSB set
    localparam logic [EXP_WIDTH-1:0]      INF_EXP  = '1;
    localparam logic [EXP_WIDTH-1:0]      NAN_EXP  = '1;
    localparam logic [MANTISSA_WIDTH-1:0] NAN_FRAC = {1'b1, {(MANTISSA_WIDTH-1){1'b0}}};

    // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact_special}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp_mul_exp_pack_classify.sv
// Operand classifier: maps a biased exponent and a fraction-nonzero bit to ZERO/NORM/INF/NAN.
// Denormals (exp == 0) are flushed and reported as ZERO.
module fp_operand_classify #(
    parameter int EXP_WIDTH = fp_mul_pkg::EXP_WIDTH
) (
    input  logic [EXP_WIDTH-1:0] exp_field,
    input  logic                 frac_nz,
    output fp_mul_pkg::fp_class_t cls
);
    import fp_mul_pkg::*;

    // Decode the operand class from the exponent extremes
    always_comb begin
        cls = NORM;
        if (exp_field == '0) begin
            cls = ZERO;
        end else if (&exp_field) begin
            if (frac_nz) begin
                cls = NAN;
            end else begin
                cls = INF;
            end
        end
    end

endmodule

// File: rtl/fp_mul_exp_pack.sv
// Exponent/sign back end of the approximate FP multiplier: computes sign and biased
// exponent, applies the mantissa unit's normalisation shift, resolves special values
// and range limits, and packs the result behind a two-stage valid/ready pipeline.
module fp_mul_exp_pack #(
    parameter int EXP_WIDTH      = fp_mul_pkg::EXP_WIDTH,
    parameter int MANTISSA_WIDTH = fp_mul_pkg::MANTISSA_WIDTH,
    parameter int BIAS           = 2**(EXP_WIDTH-1) - 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                sign_x,
    input  logic                                sign_y,
    input  logic [EXP_WIDTH-1:0]                exp_x,
    input  logic [EXP_WIDTH-1:0]                exp_y,
    input  logic                                frac_x_nz,
    input  logic                                frac_y_nz,
    input  logic [MANTISSA_WIDTH-1:0]           mant_in,
    input  logic [1:0]                          shift_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   result,
    output logic [3:0]                          flags
);
    import fp_mul_pkg::*;

    // Two guard bits keep exp_x + exp_y - BIAS (+/-1) free of wrap-around
    localparam int EW = EXP_WIDTH + 2;
    localparam int RW = 1 + EXP_WIDTH + MANTISSA_WIDTH;

    localparam logic signed [EW-1:0]        BIAS_E    = EW'(BIAS);
    localparam logic signed [EW-1:0]        EXP_MAX_E = EW'(2**EXP_WIDTH - 1);
    localparam logic [EXP_WIDTH-1:0]        EXP_ONES  = '1;
    localparam logic [MANTISSA_WIDTH-1:0]   QNAN_FRAC = {1'b1, {(MANTISSA_WIDTH-1){1'b0}}};

    // Shift code to exponent adjustment; bit1 dominates so 2'b11 counts as +1
    function automatic logic signed [EW-1:0] shift_adjust(input logic [1:0] sh);
        if (sh[1]) begin
            shift_adjust = EW'(1);
        end else if (sh[0]) begin
            shift_adjust = '0;
        end else begin
            shift_adjust = '1;
        end
    endfunction

    // Special-value and range priority mux; returns {flags, result}
    function automatic logic [RW+3:0] pack_result(
        input fp_class_t               cx,
        input fp_class_t               cy,
        input logic                    sgn,
        input logic signed [EW-1:0]    e2,
        input logic [MANTISSA_WIDTH-1:0] mant
    );
        logic [RW-1:0] r;
        logic [3:0]    fl;
        logic          any_nan;
        logic          any_inf;
        logic          any_zero;
        logic          inf_zero;
        any_nan  = (cx == NAN)  || (cy == NAN);
        any_inf  = (cx == INF)  || (cy == INF);
        any_zero = (cx == ZERO) || (cy == ZERO);
        inf_zero = any_inf && any_zero;
        fl = '0;
        if (any_nan || inf_zero) begin
            r = {1'b0, EXP_ONES, QNAN_FRAC};
            fl[FLAG_INVALID] = inf_zero;
        end else if (any_inf) begin
            r = {sgn, EXP_ONES, {MANTISSA_WIDTH{1'b0}}};
        end else if (any_zero) begin
            r = {sgn, {EXP_WIDTH{1'b0}}, {MANTISSA_WIDTH{1'b0}}};
        end else if (e2 >= EXP_MAX_E) begin
            r = {sgn, EXP_ONES, {MANTISSA_WIDTH{1'b0}}};
            fl[FLAG_OVERFLOW] = 1'b1;
            fl[FLAG_INEXACT]  = 1'b1;
        end else if (e2 <= 0) begin
            r = {sgn, {EXP_WIDTH{1'b0}}, {MANTISSA_WIDTH{1'b0}}};
            fl[FLAG_UNDERFLOW] = 1'b1;
            fl[FLAG_INEXACT]   = 1'b1;
        end else begin
            r = {sgn, e2[EXP_WIDTH-1:0], mant};
        end
        pack_result = {fl, r};
    endfunction

    fp_class_t                    cls_x, cls_y;
    logic                         adv1;
    logic signed [EW-1:0]         e1_next;
    logic signed [EW-1:0]         e2;
    logic [RW+3:0]                pack_next;

    logic                         s1_valid;
    logic                         s1_sgn;
    fp_class_t                    s1_cls_x, s1_cls_y;
    logic signed [EW-1:0]         s1_e1;
    logic [MANTISSA_WIDTH-1:0]    s1_mant;
    logic [1:0]                   s1_shift;
    logic                         s2_valid;

    fp_operand_classify #(.EXP_WIDTH(EXP_WIDTH)) u_class_x (
        .exp_field (exp_x),
        .frac_nz   (frac_x_nz),
        .cls       (cls_x)
    );

    fp_operand_classify #(.EXP_WIDTH(EXP_WIDTH)) u_class_y (
        .exp_field (exp_y),
        .frac_nz   (frac_y_nz),
        .cls       (cls_y)
    );

    assign adv1      = !s2_valid || out_ready;
    assign in_ready  = !rst && (!s1_valid || adv1);
    assign out_valid = s2_valid;

    assign e1_next   = $signed({2'b00, exp_x}) + $signed({2'b00, exp_y}) - BIAS_E;
    assign e2        = s1_e1 + shift_adjust(s1_shift);
    assign pack_next = pack_result(s1_cls_x, s1_cls_y, s1_sgn, e2, s1_mant);

    // ---- stage 1: occupancy; empties on reset, refills from in_valid whenever space opens
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 payload: sign, operand classes and unadjusted exponent captured on input transfer
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_sgn   <= sign_x ^ sign_y;
            s1_cls_x <= cls_x;
            s1_cls_y <= cls_y;
            s1_e1    <= e1_next;
            s1_mant  <= mant_in;
            s1_shift <= shift_in;
        end
    end

    // ---- stage 2: output register; advances when the consumer drains or it is empty
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            result   <= '0;
            flags    <= '0;
        end else if (adv1) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                {flags, result} <= pack_next;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_exp_pack.sv
// Directed bench for fp_mul_exp_pack (E=8, M=15, BIAS=127).
module tb_fp_mul_exp_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_x, sign_y;
    logic [7:0]  exp_x, exp_y;
    logic        frac_x_nz, frac_y_nz;
    logic [14:0] mant_in;
    logic [1:0]  shift_in;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        sx;
        logic        sy;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic        fx;
        logic        fy;
        logic [14:0] mant;
        logic [1:0]  sh;
        logic [23:0] res;
        logic [3:0]  fl;
    } vec_t;

    always #5 clk = ~clk;

    fp_mul_exp_pack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_x    (sign_x),
        .sign_y    (sign_y),
        .exp_x     (exp_x),
        .exp_y     (exp_y),
        .frac_x_nz (frac_x_nz),
        .frac_y_nz (frac_y_nz),
        .mant_in   (mant_in),
        .shift_in  (shift_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        sign_x    = v.sx;
        sign_y    = v.sy;
        exp_x     = v.ex;
        exp_y     = v.ey;
        frac_x_nz = v.fx;
        frac_y_nz = v.fy;
        mant_in   = v.mant;
        shift_in  = v.sh;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (result !== 24'h0) begin errors++; $display("FAIL reset_result got %h want 000000", result); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %h want 0", flags); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_normal();
        vec_t t[4];
        t[0] = '{1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 15'h0000, 2'b01, 24'h3F8000, 4'b0000};
        t[1] = '{1'b1, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 15'h2000, 2'b10, 24'hC02000, 4'b0000};
        t[2] = '{1'b1, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 15'h2000, 2'b00, 24'hBF2000, 4'b0000};
        t[3] = '{1'b0, 1'b1, 8'd127, 8'd127, 1'b0, 1'b0, 15'h7FFF, 2'b11, 24'hC07FFF, 4'b0000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(t[i]);
            @(negedge clk); in_valid = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL normal[%0d]_early_valid got %b want 0", i, out_valid); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL normal[%0d]_valid got %b want 1", i, out_valid); end
            checks++; if (result !== t[i].res) begin errors++; $display("FAIL normal[%0d]_result got %h want %h", i, result, t[i].res); end
            checks++; if (flags !== t[i].fl) begin errors++; $display("FAIL normal[%0d]_flags got %b want %b", i, flags, t[i].fl); end
        end
    endtask

    task automatic test_range();
        vec_t t[6];
        t[0] = '{1'b0, 1'b0, 8'd200, 8'd200, 1'b0, 1'b0, 15'h1234, 2'b01, 24'h7F8000, 4'b0101};
        t[1] = '{1'b0, 1'b0, 8'd10,  8'd10,  1'b0, 1'b0, 15'h1234, 2'b01, 24'h000000, 4'b0011};
        t[2] = '{1'b0, 1'b0, 8'd127, 8'd1,   1'b0, 1'b0, 15'h1234, 2'b00, 24'h000000, 4'b0011};
        t[3] = '{1'b0, 1'b0, 8'd127, 8'd2,   1'b0, 1'b0, 15'h0000, 2'b00, 24'h008000, 4'b0000};
        t[4] = '{1'b0, 1'b0, 8'd190, 8'd191, 1'b0, 1'b0, 15'h0055, 2'b01, 24'h7F0055, 4'b0000};
        t[5] = '{1'b1, 1'b0, 8'd191, 8'd191, 1'b0, 1'b0, 15'h0000, 2'b01, 24'hFF8000, 4'b0101};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive(t[i]);
            @(negedge clk); in_valid = 1'b0;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL range[%0d]_valid got %b want 1", i, out_valid); end
            checks++; if (result !== t[i].res) begin errors++; $display("FAIL range[%0d]_result got %h want %h", i, result, t[i].res); end
            checks++; if (flags !== t[i].fl) begin errors++; $display("FAIL range[%0d]_flags got %b want %b", i, flags, t[i].fl); end
        end
    endtask

    task automatic test_special();
        vec_t t[6];
        t[0] = '{1'b0, 1'b0, 8'd255, 8'd127, 1'b1, 1'b0, 15'h1234, 2'b01, 24'h7FC000, 4'b0000};
        t[1] = '{1'b0, 1'b0, 8'd255, 8'd0,   1'b0, 1'b0, 15'h0000, 2'b01, 24'h7FC000, 4'b1000};
        t[2] = '{1'b1, 1'b0, 8'd255, 8'd127, 1'b0, 1'b0, 15'h0000, 2'b01, 24'hFF8000, 4'b0000};
        t[3] = '{1'b1, 1'b0, 8'd0,   8'd127, 1'b0, 1'b0, 15'h1234, 2'b01, 24'h800000, 4'b0000};
        t[4] = '{1'b1, 1'b1, 8'd255, 8'd0,   1'b1, 1'b0, 15'h0000, 2'b01, 24'h7FC000, 4'b0000};
        t[5] = '{1'b0, 1'b1, 8'd0,   8'd200, 1'b0, 1'b0, 15'h0000, 2'b10, 24'h800000, 4'b0000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive(t[i]);
            @(negedge clk); in_valid = 1'b0;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL special[%0d]_valid got %b want 1", i, out_valid); end
            checks++; if (result !== t[i].res) begin errors++; $display("FAIL special[%0d]_result got %h want %h", i, result, t[i].res); end
            checks++; if (flags !== t[i].fl) begin errors++; $display("FAIL special[%0d]_flags got %b want %b", i, flags, t[i].fl); end
        end
    endtask

    task automatic test_back_to_back();
        vec_t t[4];
        t[0] = '{1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 15'h0001, 2'b01, 24'h3F8001, 4'b0000};
        t[1] = '{1'b0, 1'b0, 8'd250, 8'd250, 1'b0, 1'b0, 15'h0002, 2'b01, 24'h7F8000, 4'b0101};
        t[2] = '{1'b1, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 15'h0003, 2'b10, 24'hC00003, 4'b0000};
        t[3] = '{1'b0, 1'b0, 8'd255, 8'd0,   1'b0, 1'b0, 15'h0004, 2'b01, 24'h7FC000, 4'b1000};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b[%0d]_valid got %b want 1", c - 2, out_valid); end
                checks++; if ({flags, result} !== {t[c-2].fl, t[c-2].res}) begin errors++; $display("FAIL b2b[%0d]_out got %h/%h want %h/%h", c - 2, flags, result, t[c-2].fl, t[c-2].res); end
            end
            if (c < 4) begin
                drive(t[c]);
                #1;
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d]_in_ready got %b want 1", c, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        vec_t bp[4];
        logic [27:0] held;
        logic        was_stalled;
        int          sent;
        int          recv;
        for (int i = 0; i < 4; i++) begin
            bp[i] = '{1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 15'(16'h0111 * (i + 1)), 2'b01,
                      24'h3F8000 | 24'(16'h0111 * (i + 1)), 4'b0000};
        end
        held = '0; was_stalled = 1'b0; sent = 0; recv = 0;
        for (int c = 0; c < 40 && recv < 4; c++) begin
            @(negedge clk);
            if (was_stalled) begin
                checks++; if ({flags, result} !== held) begin errors++; $display("FAIL bp_hold_c%0d got %h want %h", c, {flags, result}, held); end
            end
            out_ready = !(c >= 2 && c <= 5);
            if (sent < 4) drive(bp[sent]);
            else in_valid = 1'b0;
            #1;
            if (c == 2) begin
                checks++; if (in_ready !== 1'b0 || sent !== 2) begin errors++; $display("FAIL bp_full in_ready %b accepted %0d want 0 and 2", in_ready, sent); end
            end
            if (c == 6) begin
                checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_drain in_ready %b out_valid %b want 1 1", in_ready, out_valid); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (recv < 4 && result !== bp[recv].res) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", recv, result, bp[recv].res); end
                recv++;
            end
            was_stalled = out_valid && !out_ready;
            held = {flags, result};
            if (in_valid && in_ready) sent++;
        end
        checks++; if (recv !== 4) begin errors++; $display("FAIL bp_count got %0d want 4", recv); end
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got %b want 0", out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        vec_t v;
        v = '{1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 15'h0ABC, 2'b01, 24'h3F8ABC, 4'b0000};
        out_ready = 1'b0;
        @(negedge clk); drive(v);
        @(negedge clk); drive(v);
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
        @(negedge clk); rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        checks++; if ({flags, result} !== 28'h0) begin errors++; $display("FAIL midrst_out got %h want 0", {flags, result}); end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d] got %b want 0", c, out_valid); end
        end
        drive(v);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || result !== v.res) begin errors++; $display("FAIL midrst_recover got %b/%h want 1/%h", out_valid, result, v.res); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sign_x = 1'b0; sign_y = 1'b0; exp_x = '0; exp_y = '0;
        frac_x_nz = 1'b0; frac_y_nz = 1'b0; mant_in = '0; shift_in = 2'b01;
        test_reset();
        test_normal();
        test_range();
        test_special();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
